// File: rtl/wb_lsu_pkg.sv
// Shared constants and types for the Wishbone load/store unit.
// Holds funct3 encodings, error causes, FSM states and request decode helpers.
package wb_lsu_pkg;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;
    localparam logic [2:0] FUNCT3_SB  = 3'b000;
    localparam logic [2:0] FUNCT3_SH  = 3'b001;
    localparam logic [2:0] FUNCT3_SW  = 3'b010;

    typedef enum logic [1:0] {
        LSU_CAUSE_MISALIGNED = 2'd0,
        LSU_CAUSE_BUS        = 2'd1,
        LSU_CAUSE_TIMEOUT    = 2'd2,
        LSU_CAUSE_ILLEGAL    = 2'd3
    } lsu_cause_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUS,
        ST_RETRY,
        ST_RESP
    } lsu_state_e;

    // Stores only exist for byte/half/word; unsigned variants are load-only.
    function automatic logic funct3_illegal(input logic we, input logic [2:0] f3);
        return (f3 == 3'b011) || (f3[2:1] == 2'b11) || (we && f3[2]);
    endfunction

    function automatic logic addr_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        logic mis;
        mis = 1'b0;
        if (f3[1:0] == FUNCT3_LH[1:0]) begin
            mis = lo[0];
        end else if (f3[1:0] == FUNCT3_LW[1:0]) begin
            mis = (lo != 2'b00);
        end
        return mis;
    endfunction

endpackage

// File: rtl/wb_lsu_if.sv
// Classic single-beat Wishbone bus between the load/store unit and a slave.
interface wb_lsu_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  cyc_o;
    logic                  stb_o;
    logic                  we_o;
    logic [ADDR_WIDTH-1:0] adr_o;
    logic [3:0]            sel_o;
    logic [31:0]           dat_o;
    logic [31:0]           dat_i;
    logic                  ack_i;
    logic                  err_i;
    logic                  rty_i;

    modport master (
        output cyc_o, stb_o, we_o, adr_o, sel_o, dat_o,
        input  dat_i, ack_i, err_i, rty_i
    );

    modport slave (
        input  cyc_o, stb_o, we_o, adr_o, sel_o, dat_o,
        output dat_i, ack_i, err_i, rty_i
    );
endinterface

// File: rtl/wb_lsu_align.sv
// Byte-lane steering for stores and lane select plus sign/zero extension for loads.
module lsu_align
    import wb_lsu_pkg::*;
(
    input  logic        st_we_i,
    input  logic [2:0]  st_funct3_i,
    input  logic [1:0]  st_addr_lo_i,
    input  logic [31:0] st_wdata_i,
    output logic [3:0]  st_sel_o,
    output logic [31:0] st_dat_o,
    input  logic [2:0]  ld_funct3_i,
    input  logic [1:0]  ld_addr_lo_i,
    input  logic [31:0] ld_data_i,
    output logic [31:0] ld_data_o
);
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic        ld_signed;

    always_comb begin
        st_sel_o = 4'b1111;
        st_dat_o = st_wdata_i;
        if (st_funct3_i[1:0] == FUNCT3_SB[1:0]) begin
            st_sel_o = 4'b0001 << st_addr_lo_i;
            st_dat_o = {4{st_wdata_i[7:0]}};
        end else if (st_funct3_i[1:0] == FUNCT3_SH[1:0]) begin
            st_sel_o = 4'b0011 << st_addr_lo_i;
            st_dat_o = {2{st_wdata_i[15:0]}};
        end
        if (!st_we_i) begin
            st_dat_o = '0;
        end
    end

    always_comb begin
        ld_byte   = ld_data_i[{ld_addr_lo_i, 3'b000} +: 8];
        ld_half   = ld_data_i[{ld_addr_lo_i[1], 4'b0000} +: 16];
        ld_signed = ~ld_funct3_i[2];
        ld_data_o = ld_data_i;
        if (ld_funct3_i[1:0] == FUNCT3_LB[1:0]) begin
            ld_data_o = {{24{ld_byte[7] & ld_signed}}, ld_byte};
        end else if (ld_funct3_i[1:0] == FUNCT3_LH[1:0]) begin
            ld_data_o = {{16{ld_half[15] & ld_signed}}, ld_half};
        end
    end

endmodule

// File: rtl/wb_lsu.sv
// RV32 load/store unit driving single-beat Wishbone cycles with retry,
// timeout, misalignment and illegal-funct3 handling.
module wb_lsu
    import wb_lsu_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned RETRY_LIMIT    = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [2:0]            req_funct3_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [31:0]           req_wdata_i,
    output logic                  rsp_valid_o,
    output logic [31:0]           rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic [1:0]            rsp_cause_o,
    wb_lsu_if.master              wb
);
    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned RT_W = (RETRY_LIMIT > 0) ? $clog2(RETRY_LIMIT + 1) : 1;

    lsu_state_e            state_q, state_d;
    logic [TO_W-1:0]       to_q, to_d;
    logic [RT_W-1:0]       retry_q, retry_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [1:0]            addr_lo_q, addr_lo_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] adr_q, adr_d;
    logic [3:0]            sel_q, sel_d;
    logic [31:0]           dat_q, dat_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [31:0]           rsp_rdata_q, rsp_rdata_d;
    lsu_cause_e            rsp_cause_q, rsp_cause_d;

    logic [3:0]            st_sel;
    logic [31:0]           st_dat;
    logic [31:0]           ld_data;

    lsu_align u_align (
        .st_we_i      (req_we_i),
        .st_funct3_i  (req_funct3_i),
        .st_addr_lo_i (req_addr_i[1:0]),
        .st_wdata_i   (req_wdata_i),
        .st_sel_o     (st_sel),
        .st_dat_o     (st_dat),
        .ld_funct3_i  (funct3_q),
        .ld_addr_lo_i (addr_lo_q),
        .ld_data_i    (wb.dat_i),
        .ld_data_o    (ld_data)
    );

    always_comb begin
        state_d     = state_q;
        to_d        = to_q;
        retry_d     = retry_q;
        funct3_d    = funct3_q;
        addr_lo_d   = addr_lo_q;
        we_d        = we_q;
        adr_d       = adr_q;
        sel_d       = sel_q;
        dat_d       = dat_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        rsp_cause_d = LSU_CAUSE_MISALIGNED;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    if (funct3_illegal(req_we_i, req_funct3_i)) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_cause_d = LSU_CAUSE_ILLEGAL;
                    end else if (addr_misaligned(req_funct3_i, req_addr_i[1:0])) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_cause_d = LSU_CAUSE_MISALIGNED;
                    end else begin
                        state_d   = ST_BUS;
                        to_d      = '0;
                        retry_d   = '0;
                        funct3_d  = req_funct3_i;
                        addr_lo_d = req_addr_i[1:0];
                        we_d      = req_we_i;
                        adr_d     = {req_addr_i[ADDR_WIDTH-1:2], 2'b00};
                        sel_d     = st_sel;
                        dat_d     = st_dat;
                    end
                end
            end
            ST_BUS: begin
                if (wb.err_i) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_cause_d = LSU_CAUSE_BUS;
                end else if (wb.ack_i) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = we_q ? '0 : ld_data;
                end else if (wb.rty_i) begin
                    if (retry_q < RT_W'(RETRY_LIMIT)) begin
                        state_d = ST_RETRY;
                        retry_d = retry_q + 1'b1;
                    end else begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_cause_d = LSU_CAUSE_BUS;
                    end
                end else if (TIMEOUT_CYCLES != 0) begin
                    // to_q counts unterminated edges already seen; this edge is one more.
                    if (to_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_cause_d = LSU_CAUSE_TIMEOUT;
                    end else begin
                        to_d = to_q + 1'b1;
                    end
                end
            end
            ST_RETRY: begin
                state_d = ST_BUS;
                to_d    = '0;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            to_q        <= '0;
            retry_q     <= '0;
            funct3_q    <= '0;
            addr_lo_q   <= '0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            sel_q       <= '0;
            dat_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_cause_q <= LSU_CAUSE_MISALIGNED;
        end else begin
            state_q     <= state_d;
            to_q        <= to_d;
            retry_q     <= retry_d;
            funct3_q    <= funct3_d;
            addr_lo_q   <= addr_lo_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            sel_q       <= sel_d;
            dat_q       <= dat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_cause_q <= rsp_cause_d;
        end
    end

    assign req_ready_o = (state_q == ST_IDLE);
    assign wb.cyc_o    = (state_q == ST_BUS);
    assign wb.stb_o    = (state_q == ST_BUS);
    assign wb.we_o     = we_q;
    assign wb.adr_o    = adr_q;
    assign wb.sel_o    = sel_q;
    assign wb.dat_o    = dat_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_cause_o = rsp_cause_q;

endmodule
